// File: rtl/bt656_pkg.sv
// Shared definitions for the BT.656 timing-reference decoder: sync byte
// values, decoder state encoding, decoded XY flags and protection check.
package bt656_pkg;

    localparam logic [7:0] SYNC_FF = 8'hFF;
    localparam logic [7:0] SYNC_00 = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        P1,
        P2,
        XY,
        ACTIVE
    } state_t;

    typedef struct packed {
        logic f;
        logic v;
        logic h;
    } xy_t;

    // Protection nibble of an XY byte: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
    function automatic logic prot_ok(input logic [7:0] xy);
        prot_ok = (xy[3] == (xy[5] ^ xy[4]))
               && (xy[2] == (xy[6] ^ xy[4]))
               && (xy[1] == (xy[6] ^ xy[5]))
               && (xy[0] == (xy[6] ^ xy[5] ^ xy[4]));
    endfunction

endpackage

// File: rtl/bt656_xy_check.sv
// Combinational decode of a BT.656 XY byte into F/V/H flags.
// Optional macro: BT656_PROT_CHECK_EN -- when defined the protection nibble
// must match the flags; when undefined bits 3:0 are not enforced.
module bt656_xy_check
    import bt656_pkg::*;
(
    input  logic [7:0] xy_byte,
    output xy_t        flags,
    output logic       valid,
    output logic       prot_good
);

`ifdef BT656_PROT_CHECK_EN
    localparam bit PROT_CHECK = 1'b1;
`else
    localparam bit PROT_CHECK = 1'b0;
`endif

    assign flags.f   = xy_byte[6];
    assign flags.v   = xy_byte[5];
    assign flags.h   = xy_byte[4];
    // Bit 7 of every timing reference code is fixed at 1.
    assign valid     = xy_byte[7];
    // Protection is always decoded, but only enforced when the check is built in.
    assign prot_good = prot_ok(xy_byte) || !PROT_CHECK;

endmodule

// File: rtl/bt656_sync_decoder.sv
// BT.656 sync decoder: finds FF 00 00 XY codes, tracks field/line framing and
// forwards active-video bytes with sop/eol markers one cycle after input.
// Optional macro: BT656_PROT_CHECK_EN (XY protection-bit checking, in bt656_xy_check).
module bt656_sync_decoder
    import bt656_pkg::*;
#(
    parameter int H_ACTIVE = 1440,
    parameter int LINE_W   = 10
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              td_ready,
    input  logic [7:0]        td_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eol,
    output logic              field,
    output logic              field_done,
    output logic [LINE_W-1:0] line_cnt,
    output logic              locked,
    output logic [7:0]        err_cnt
);

    // Pixel counter must reach H_ACTIVE+1, which marks "overflow already counted".
    localparam int PIX_W = $clog2(H_ACTIVE + 2);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(H_ACTIVE - 1);
    localparam logic [PIX_W-1:0] PIX_FULL = PIX_W'(H_ACTIVE);
    localparam logic [PIX_W-1:0] PIX_OVER = PIX_W'(H_ACTIVE + 1);

    state_t            state_reg, state_next;
    logic [PIX_W-1:0]  pix_cnt_reg, pix_cnt_next;
    logic [7:0]        out_data_reg, out_data_next;
    logic              out_valid_reg, out_valid_next;
    logic              out_sop_reg, out_sop_next;
    logic              out_eol_reg, out_eol_next;
    logic              field_reg, field_next;
    logic              field_done_reg, field_done_next;
    logic [LINE_W-1:0] line_cnt_reg, line_cnt_next;
    logic              locked_reg, locked_next;
    logic [7:0]        err_cnt_reg, err_cnt_next;
    logic              sop_pending_reg, sop_pending_next;
    logic              sop_line_reg, sop_line_next;
    logic              line_active_reg, line_active_next;
    logic              prev_v_reg, prev_v_next;
    logic              err_event;
    logic              sop_arm;

    xy_t  xy_flags;
    logic xy_valid;
    logic xy_prot_good;

    bt656_xy_check u_xy_check (
        .xy_byte   (td_data),
        .flags     (xy_flags),
        .valid     (xy_valid),
        .prot_good (xy_prot_good)
    );

    // State and output registers; sop is armed out of reset so the first field starts a packet.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_reg       <= IDLE;
            pix_cnt_reg     <= '0;
            out_data_reg    <= '0;
            out_valid_reg   <= 1'b0;
            out_sop_reg     <= 1'b0;
            out_eol_reg     <= 1'b0;
            field_reg       <= 1'b0;
            field_done_reg  <= 1'b0;
            line_cnt_reg    <= '0;
            locked_reg      <= 1'b0;
            err_cnt_reg     <= '0;
            sop_pending_reg <= 1'b1;
            sop_line_reg    <= 1'b0;
            line_active_reg <= 1'b0;
            prev_v_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pix_cnt_reg     <= pix_cnt_next;
            out_data_reg    <= out_data_next;
            out_valid_reg   <= out_valid_next;
            out_sop_reg     <= out_sop_next;
            out_eol_reg     <= out_eol_next;
            field_reg       <= field_next;
            field_done_reg  <= field_done_next;
            line_cnt_reg    <= line_cnt_next;
            locked_reg      <= locked_next;
            err_cnt_reg     <= err_cnt_next;
            sop_pending_reg <= sop_pending_next;
            sop_line_reg    <= sop_line_next;
            line_active_reg <= line_active_next;
            prev_v_reg      <= prev_v_next;
        end
    end

    // Next-state decode: sync-code search, XY interpretation and active-video forwarding.
    always_comb begin
        state_next       = state_reg;
        pix_cnt_next     = pix_cnt_reg;
        out_data_next    = out_data_reg;
        out_valid_next   = 1'b0;
        out_sop_next     = 1'b0;
        out_eol_next     = 1'b0;
        field_next       = field_reg;
        field_done_next  = 1'b0;
        line_cnt_next    = line_cnt_reg;
        locked_next      = locked_reg;
        sop_pending_next = sop_pending_reg;
        sop_line_next    = sop_line_reg;
        line_active_next = line_active_reg;
        prev_v_next      = prev_v_reg;
        err_event        = 1'b0;
        sop_arm          = sop_pending_reg | xy_flags.v | (xy_flags.f != field_reg);

        if (!td_ready) begin
            // Decoder held in reset: drop lock and abandon the current line.
            state_next       = IDLE;
            locked_next      = 1'b0;
            line_active_next = 1'b0;
        end else begin
            unique case (state_reg)
                IDLE:   state_next = SEARCH;
                SEARCH: if (td_data == SYNC_FF) state_next = P1;
                P1: begin
                    if (td_data == SYNC_00)      state_next = P2;
                    else if (td_data != SYNC_FF) state_next = SEARCH;
                end
                P2:     state_next = (td_data == SYNC_00) ? XY : SEARCH;
                XY: begin
                    state_next = SEARCH;
                    if (!xy_valid || !xy_prot_good) begin
                        err_event = 1'b1;
                    end else begin
                        field_next       = xy_flags.f;
                        prev_v_next      = xy_flags.v;
                        sop_pending_next = sop_arm;
                        if (xy_flags.h) begin
                            // EAV closes the line; first vertical-blanking EAV ends the field.
                            if (!xy_flags.v && line_active_reg)
                                line_cnt_next = line_cnt_reg + 1'b1;
                            line_active_next = 1'b0;
                            field_done_next  = xy_flags.v && !prev_v_reg;
                        end else if (!xy_flags.v) begin
                            // SAV in the active region opens a line.
                            state_next       = ACTIVE;
                            pix_cnt_next     = '0;
                            locked_next      = 1'b1;
                            line_active_next = 1'b1;
                            sop_line_next    = sop_arm;
                            sop_pending_next = 1'b0;
                            if (sop_arm) line_cnt_next = '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (td_data == SYNC_FF) begin
                        state_next = P1;
                        if (pix_cnt_reg < PIX_FULL) err_event = 1'b1;
                    end else if (pix_cnt_reg < PIX_FULL) begin
                        out_valid_next = 1'b1;
                        out_data_next  = td_data;
                        out_sop_next   = sop_line_reg && (pix_cnt_reg == '0);
                        out_eol_next   = (pix_cnt_reg == PIX_LAST);
                        pix_cnt_next   = pix_cnt_reg + 1'b1;
                    end else if (pix_cnt_reg == PIX_FULL) begin
                        // First surplus byte: one error for the whole overlong line.
                        err_event    = 1'b1;
                        pix_cnt_next = PIX_OVER;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        err_cnt_next = (err_event && err_cnt_reg != 8'hFF) ? err_cnt_reg + 8'd1 : err_cnt_reg;
    end

    assign out_data   = out_data_reg;
    assign out_valid  = out_valid_reg;
    assign out_sop    = out_sop_reg;
    assign out_eol    = out_eol_reg;
    assign field      = field_reg;
    assign field_done = field_done_reg;
    assign line_cnt   = line_cnt_reg;
    assign locked     = locked_reg;
    assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_bt656_sync_decoder.sv
// Directed testbench for bt656_sync_decoder. Expectations depend on whether
// BT656_PROT_CHECK_EN is defined for the build.
module tb_bt656_sync_decoder;

    localparam int H_ACTIVE = 1440;
    localparam int LINE_W   = 10;

`ifdef BT656_PROT_CHECK_EN
    localparam int PROT_EMIT = 0;
    localparam int PROT_SOP  = 0;
    localparam int PROT_ERR  = 1;
    localparam int LC_T7     = 0;
`else
    localparam int PROT_EMIT = H_ACTIVE;
    localparam int PROT_SOP  = 1;
    localparam int PROT_ERR  = 0;
    localparam int LC_T7     = 1;
`endif

    logic              clock = 1'b0;
    logic              nreset = 1'b0;
    logic              td_ready = 1'b0;
    logic [7:0]        td_data = 8'h00;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_sop;
    logic              out_eol;
    logic              field;
    logic              field_done;
    logic [LINE_W-1:0] line_cnt;
    logic              locked;
    logic [7:0]        err_cnt;

    bt656_sync_decoder #(.H_ACTIVE(H_ACTIVE), .LINE_W(LINE_W)) dut (
        .clock      (clock),
        .nreset     (nreset),
        .td_ready   (td_ready),
        .td_data    (td_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eol    (out_eol),
        .field      (field),
        .field_done (field_done),
        .line_cnt   (line_cnt),
        .locked     (locked),
        .err_cnt    (err_cnt)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Expected stream: each byte marked for emission must appear exactly one cycle later.
    logic       exp_emit = 1'b0;
    logic       exp_v_d = 1'b0;
    logic [7:0] exp_d_d = 8'h00;
    int mon_cnt = 0, mon_bad = 0, sop_cnt = 0, sop_at = -1, eol_cnt = 0, eol_at = -1, fd_cnt = 0;

    always @(posedge clock) begin
        exp_v_d <= exp_emit;
        exp_d_d <= td_data;
    end

    always @(negedge clock) begin
        if (out_valid !== exp_v_d || (exp_v_d && out_data !== exp_d_d)) mon_bad++;
        if (out_valid) begin
            if (out_sop) begin sop_cnt++; sop_at = mon_cnt; end
            if (out_eol) begin eol_cnt++; eol_at = mon_cnt; end
            mon_cnt++;
        end else if (out_sop || out_eol) begin
            mon_bad++;
        end
        if (field_done) fd_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic emit);
        @(posedge clock);
        #1;
        td_data  = b;
        exp_emit = emit;
    endtask

    task automatic send_code(input logic [7:0] xy);
        send(8'hFF, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(xy, 1'b0);
    endtask

    task automatic send_payload(input int first, input int n, input int emit_lim);
        for (int i = first; i < first + n; i++)
            send(8'h10 + 8'(i % 224), i < emit_lim);
    endtask

    task automatic flush();
        send(8'h10, 1'b0);
        send(8'h10, 1'b0);
    endtask

    // One video line: SAV, n payload bytes (first n_emit expected out), EAV.
    task automatic run_line(input string tag, input logic [7:0] sav, input logic [7:0] eav,
                            input int n, input int n_emit, input int exp_sop, input int exp_line);
        int b_cnt, b_sop, b_eol;
        b_cnt = mon_cnt; b_sop = sop_cnt; b_eol = eol_cnt;
        send_code(sav);
        send_payload(0, 8, n_emit);
        if (exp_line >= 0) chk({tag, "_line_cnt"}, int'(line_cnt), exp_line);
        send_payload(8, n - 8, n_emit);
        send_code(eav);
        flush();
        chk({tag, "_bytes"}, mon_cnt - b_cnt, n_emit);
        chk({tag, "_sop"}, sop_cnt - b_sop, exp_sop);
        if (exp_sop == 1) chk({tag, "_sop_pos"}, sop_at - b_cnt, 0);
        chk({tag, "_eol"}, eol_cnt - b_eol, (n_emit == H_ACTIVE) ? 1 : 0);
        if (n_emit == H_ACTIVE) chk({tag, "_eol_pos"}, eol_at - b_cnt, H_ACTIVE - 1);
        chk({tag, "_stream"}, mon_bad, 0);
        $display("[TB] %s sav=%02h eav=%02h bytes_in=%0d emitted=%0d err_cnt=%0d line_cnt=%0d",
                 tag, sav, eav, n, mon_cnt - b_cnt, err_cnt, line_cnt);
    endtask

    int b_cnt, b_fd;

    initial begin
        // Reset, decoder not ready: nothing may come out even with a valid SAV.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err", int'(err_cnt), 0);
        nreset = 1'b1;
        send_code(8'h80);
        send_payload(0, 16, 0);
        flush();
        chk("idle_valid_cnt", mon_cnt, 0);
        chk("idle_locked", int'(locked), 0);
        chk("idle_field", int'(field), 0);
        chk("idle_line_cnt", int'(line_cnt), 0);
        chk("idle_err", int'(err_cnt), 0);
        chk("idle_field_done", fd_cnt, 0);
        chk("idle_out_data", int'(out_data), 0);
        $display("[TB] idle stream with td_ready=0: emitted=%0d", mon_cnt);

        // First full line after td_ready rises.
        td_ready = 1'b1;
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        run_line("first", 8'h80, 8'h9D, H_ACTIVE, H_ACTIVE, 1, 0);
        chk("first_locked", int'(locked), 1);
        chk("first_err", int'(err_cnt), 0);
        chk("first_field", int'(field), 0);
        chk("first_line_after", int'(line_cnt), 1);

        // Short line, then a normal line.
        run_line("short", 8'h80, 8'h9D, 1000, 1000, 0, 1);
        chk("short_err", int'(err_cnt), 1);
        run_line("after_short", 8'h80, 8'h9D, H_ACTIVE, H_ACTIVE, 0, 2);
        chk("after_short_err", int'(err_cnt), 1);

        // Overlong line: surplus bytes dropped, a single error.
        run_line("long", 8'h80, 8'h9D, H_ACTIVE + 3, H_ACTIVE, 0, 3);
        chk("long_err", int'(err_cnt), 2);

        // Field: blanking, three active lines, blanking EAV.
        b_fd = fd_cnt;
        run_line("blank", 8'hAB, 8'hB6, H_ACTIVE, 0, 0, -1);
        run_line("field_l0", 8'h80, 8'h9D, H_ACTIVE, H_ACTIVE, 1, 0);
        run_line("field_l1", 8'h80, 8'h9D, H_ACTIVE, H_ACTIVE, 0, 1);
        run_line("field_l2", 8'h80, 8'h9D, H_ACTIVE, H_ACTIVE, 0, 2);
        send_code(8'hB6);
        flush();
        chk("field_done_pulses", fd_cnt - b_fd, 1);
        chk("field_flag", int'(field), 0);
        chk("field_line_end", int'(line_cnt), 3);
        chk("field_err", int'(err_cnt), 2);

        // F flag change starts a new packet.
        run_line("field1", 8'hC7, 8'hDA, H_ACTIVE, H_ACTIVE, 1, 0);
        chk("field1_flag", int'(field), 1);

        // SAV with a broken P0 bit.
        run_line("prot", 8'h81, 8'h9D, H_ACTIVE, PROT_EMIT, PROT_SOP, -1);
        chk("prot_err", int'(err_cnt), 2 + PROT_ERR);

        // td_ready drops at byte 500 of an active line.
        b_cnt = mon_cnt;
        send_code(8'h80);
        send_payload(0, 500, 500);
        @(posedge clock);
        #1;
        td_ready = 1'b0;
        td_data  = 8'h10 + 8'(500 % 224);
        exp_emit = 1'b0;
        send_payload(501, 1, 0);
        chk("drop_valid", int'(out_valid), 0);
        chk("drop_locked", int'(locked), 0);
        chk("drop_line_hold", int'(line_cnt), LC_T7);
        chk("drop_err_hold", int'(err_cnt), 2 + PROT_ERR);
        send_payload(502, H_ACTIVE - 502, 0);
        chk("drop_bytes", mon_cnt - b_cnt, 500);
        td_ready = 1'b1;
        send_code(8'h9D);
        send_code(8'h9D);
        flush();
        chk("resume_no_lock", int'(locked), 0);
        $display("[TB] drop line: emitted=%0d before td_ready fell", mon_cnt - b_cnt);
        run_line("resume", 8'h80, 8'h9D, H_ACTIVE, H_ACTIVE, 0, LC_T7);
        chk("resume_locked", int'(locked), 1);

        // Bad XY codes (bit 7 clear) drive err_cnt to saturation.
        for (int i = 0; i < 10; i++) send_code(8'h00);
        flush();
        chk("err_ten", int'(err_cnt), 12 + PROT_ERR);
        for (int i = 0; i < 250; i++) send_code(8'h00);
        flush();
        chk("err_saturate", int'(err_cnt), 255);
        chk("final_stream", mon_bad, 0);
        $display("[TB] bad XY codes sent=260 err_cnt=%0d", err_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
